// File: rtl/cordic_fp_sequencer.sv
// Iterative rotation-mode CORDIC sequencer producing cos/sin of a float angle.
// All x/y/z updates are routed through one external pipelined float adder.
module cordic_fp_sequencer #(
  parameter int ITERATIONS  = 16,
  parameter int ADD_LATENCY = 7
) (
  input  logic        clock,
  input  logic        aclr,
  input  logic        start,
  input  logic [31:0] theta,
  output logic        busy,
  output logic        done,
  output logic [31:0] cos_out,
  output logic [31:0] sin_out,
  output logic [31:0] add_dataa,
  output logic [31:0] add_datab,
  output logic        add_sub,
  output logic        add_clk_en,
  input  logic [31:0] add_result
);

  localparam logic [31:0] K_INIT    = 32'h3F1B74EE;
  localparam logic [4:0]  LAST_ITER = 5'(ITERATIONS - 1);
  localparam int unsigned LAT       = ADD_LATENCY;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state, state_next;
  logic [1:0]  sub;
  logic [4:0]  iter;
  logic [31:0] x, y, z;
  logic [31:0] a_hold, b_hold;
  logic        op_hold;
  logic [31:0] a_issue, b_issue;
  logic        op_issue;
  logic [2:0]  tags [LAT];
  logic        cap_valid;
  logic [1:0]  cap_sel;
  logic        last_cap;
  logic        finish;

  function automatic logic [31:0] atan_rom(input logic [4:0] idx);
    case (idx)
      5'd0:  return 32'h3F490FDB;
      5'd1:  return 32'h3EED6338;
      5'd2:  return 32'h3E7ADBB0;
      5'd3:  return 32'h3DFEADD5;
      5'd4:  return 32'h3D7FAADE;
      5'd5:  return 32'h3CFFEAAE;
      5'd6:  return 32'h3C7FFAAB;
      5'd7:  return 32'h3BFFFEAB;
      5'd8:  return 32'h3B7FFFAB;
      5'd9:  return 32'h3AFFFFEB;
      5'd10: return 32'h3A7FFFFB;
      5'd11: return 32'h39FFFFFF;
      5'd12: return 32'h39800000;
      5'd13: return 32'h39000000;
      5'd14: return 32'h38800000;
      5'd15: return 32'h38000000;
      5'd16: return 32'h37800000;
      5'd17: return 32'h37000000;
      5'd18: return 32'h36800000;
      5'd19: return 32'h36000000;
      5'd20: return 32'h35800000;
      5'd21: return 32'h35000000;
      5'd22: return 32'h34800000;
      5'd23: return 32'h34000000;
      default: return '0;
    endcase
  endfunction

  // Multiply by 2^-sh through the exponent; anything that would underflow flushes to +0.
  function automatic logic [31:0] scale(input logic [31:0] v, input logic [4:0] sh);
    if (sh == 5'd0) return v;
    if (v[30:23] <= {3'b000, sh}) return '0;
    return {v[31], v[30:23] - {3'b000, sh}, v[22:0]};
  endfunction

  always_comb begin
    a_issue  = x;
    b_issue  = scale(y, iter);
    op_issue = z[31];
    case (sub)
      2'd1: begin
        a_issue  = y;
        b_issue  = scale(x, iter);
        op_issue = ~z[31];
      end
      2'd2: begin
        a_issue  = z;
        b_issue  = atan_rom(iter);
        op_issue = z[31];
      end
      default: ;
    endcase
  end

  assign cap_valid  = tags[LAT-1][2];
  assign cap_sel    = tags[LAT-1][1:0];
  assign last_cap   = cap_valid && (cap_sel == 2'd2);
  assign finish     = (state == WAIT) && last_cap && (iter == LAST_ITER);

  assign add_clk_en = (state != IDLE);
  assign busy       = (state == ISSUE) || (state == WAIT);
  assign add_dataa  = (state == ISSUE) ? a_issue  : a_hold;
  assign add_datab  = (state == ISSUE) ? b_issue  : b_hold;
  assign add_sub    = (state == ISSUE) ? op_issue : op_hold;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = ISSUE;
      ISSUE: if (sub == 2'd2) state_next = WAIT;
      WAIT:  if (last_cap) state_next = (iter == LAST_ITER) ? DONE : ISSUE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int unsigned k = 0; k < LAT; k++) tags[k] <= '0;
      sub     <= '0;
      iter    <= '0;
      x       <= '0;
      y       <= '0;
      z       <= '0;
      a_hold  <= '0;
      b_hold  <= '0;
      op_hold <= 1'b0;
      done    <= 1'b0;
      cos_out <= '0;
      sin_out <= '0;
    end else begin
      if (add_clk_en) begin
        tags[0] <= {state == ISSUE, sub};
        for (int unsigned k = 1; k < LAT; k++) tags[k] <= tags[k-1];
        if (cap_valid) begin
          case (cap_sel)
            2'd0:    x <= add_result;
            2'd1:    y <= add_result;
            2'd2:    z <= add_result;
            default: ;
          endcase
        end
      end
      case (state)
        IDLE: if (start) begin
          x    <= K_INIT;
          y    <= '0;
          z    <= theta;
          iter <= '0;
          sub  <= '0;
        end
        ISSUE: begin
          a_hold  <= a_issue;
          b_hold  <= b_issue;
          op_hold <= op_issue;
          sub     <= (sub == 2'd2) ? 2'd0 : sub + 2'd1;
        end
        WAIT: if (last_cap && iter != LAST_ITER) iter <= iter + 5'd1;
        default: ;
      endcase
      // x and y settled two captures earlier, so they can be published alongside the final z capture.
      done <= finish;
      if (finish) begin
        cos_out <= x;
        sin_out <= y;
      end
    end
  end

endmodule
